// File: rtl/stream_write_buffer_pkg.sv
// Shared types and constants for the stream write buffer: FSM encoding, default FIFO depth and
// beat-count width.
package stream_write_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned FifoAddrWDefault = 9;
  localparam int unsigned BeatNumWidth     = 24;

endpackage

// File: rtl/stream_write_buffer_fifo.sv
// First-word-fall-through FIFO with a registered head (o_data/o_valid); o_count counts every
// stored entry, including the one currently presented on the output.
module stream_write_buffer_fifo
  import stream_write_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_W     = FifoAddrWDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_full
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam logic [ADDR_W:0] CntFull = CntW'(Depth);
  localparam logic [ADDR_W:0] CntOne  = CntW'(1);

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [ADDR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic                  w_push, w_pop;
  logic [ADDR_W:0]       w_count_d;
  logic [ADDR_W-1:0]     w_rd_next;
  logic [DATA_WIDTH-1:0] w_head_d;

  assign o_full    = (r_count == CntFull);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && r_valid;
  assign w_count_d = r_count + CntW'(w_push) - CntW'(w_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;

  // The head bypasses the RAM when the entry being pushed becomes the only one left.
  always_comb begin
    w_head_d = r_data;
    if (w_pop) begin
      if (r_count == CntOne) w_head_d = i_push_data;
      else                   w_head_d = r_mem[w_rd_next];
    end else if (r_count == '0) begin
      w_head_d = i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_count <= w_count_d;
      r_valid <= (w_count_d != '0);
      if (w_push || w_pop) r_data <= w_head_d;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/stream_write_buffer.sv
// Buffers the compute-stage output stream toward the write DMA, regenerates TLAST from the beat
// count and pulses Write_Complete. Define WRITE_LAST_CHECK_EN to check S_Last into Last_Error.
module stream_write_buffer
  import stream_write_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,  // must equal `AXI_WIDTH_DATA_IN
  parameter int unsigned FIFO_ADDR_W    = FifoAddrWDefault,
  parameter int unsigned WIDTH_BEAT_NUM = BeatNumWidth
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [WIDTH_BEAT_NUM-1:0] Beat_Num_REG,
  input  logic [DATA_WIDTH-1:0]     S_Data,
  input  logic                      S_Valid,
  output logic                      S_Ready,
  input  logic                      S_Last,
  output logic [DATA_WIDTH-1:0]     M_Data,
  output logic                      M_Valid,
  input  logic                      M_Ready,
  output logic                      M_Last,
  output logic [FIFO_ADDR_W:0]      Fifo_Count,
  output logic                      Write_Complete,
  output logic                      Last_Error
);

  localparam logic [WIDTH_BEAT_NUM-1:0] BeatOne = WIDTH_BEAT_NUM'(1);

  state_e                    r_state;
  logic [WIDTH_BEAT_NUM-1:0] r_in_left, r_out_left;
  logic                      r_write_complete;

  logic w_full, w_push, w_pop;

  assign S_Ready = (r_state == StRun) && !w_full && (r_in_left != '0);
  assign w_push  = S_Valid && S_Ready;
  assign w_pop   = M_Valid && M_Ready;
  assign M_Last  = M_Valid && (r_out_left == BeatOne);
  assign Write_Complete = r_write_complete;

  stream_write_buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (FIFO_ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (S_Data),
    .i_pop       (w_pop),
    .o_data      (M_Data),
    .o_valid     (M_Valid),
    .o_count     (Fifo_Count),
    .o_full      (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= StIdle;
      r_in_left        <= '0;
      r_out_left       <= '0;
      r_write_complete <= 1'b0;
    end else begin
      r_write_complete <= 1'b0;
      if (w_pop) r_out_left <= r_out_left - BeatOne;
      unique case (r_state)
        StIdle: begin
          if (Start) begin
            if (Beat_Num_REG != '0) begin
              r_in_left  <= Beat_Num_REG;
              r_out_left <= Beat_Num_REG;
              r_state    <= StRun;
            end else begin
              r_state          <= StDone;
              r_write_complete <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_push) begin
            r_in_left <= r_in_left - BeatOne;
            if (r_in_left == BeatOne) r_state <= StDrain;
          end
        end
        StDrain: begin
          if ((r_out_left == '0) || (w_pop && (r_out_left == BeatOne))) begin
            r_state          <= StDone;
            r_write_complete <= 1'b1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef WRITE_LAST_CHECK_EN
  logic r_last_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_error <= 1'b0;
    end else if ((r_state == StIdle) && Start) begin
      r_last_error <= 1'b0;
    end else if (w_push && (S_Last != (r_in_left == BeatOne))) begin
      r_last_error <= 1'b1;
    end
  end

  assign Last_Error = r_last_error;
`else
  logic w_unused_s_last;
  assign w_unused_s_last = S_Last;
  assign Last_Error      = 1'b0;
`endif

endmodule

// File: tb/tb_stream_write_buffer.sv
// Directed bench for stream_write_buffer with a 4-entry FIFO; honours WRITE_LAST_CHECK_EN.
module tb_stream_write_buffer;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 2;
  localparam int unsigned BW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [BW-1:0] Beat_Num_REG;
  logic [DW-1:0] S_Data;
  logic          S_Valid;
  logic          S_Ready;
  logic          S_Last;
  logic [DW-1:0] M_Data;
  logic          M_Valid;
  logic          M_Ready;
  logic          M_Last;
  logic [AW:0]   Fifo_Count;
  logic          Write_Complete;
  logic          Last_Error;

  stream_write_buffer #(
    .DATA_WIDTH     (DW),
    .FIFO_ADDR_W    (AW),
    .WIDTH_BEAT_NUM (BW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Start          (Start),
    .Beat_Num_REG   (Beat_Num_REG),
    .S_Data         (S_Data),
    .S_Valid        (S_Valid),
    .S_Ready        (S_Ready),
    .S_Last         (S_Last),
    .M_Data         (M_Data),
    .M_Valid        (M_Valid),
    .M_Ready        (M_Ready),
    .M_Last         (M_Last),
    .Fifo_Count     (Fifo_Count),
    .Write_Complete (Write_Complete),
    .Last_Error     (Last_Error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stream scoreboard state
  int          n_beats;
  logic [63:0] base;
  int          in_idx, out_idx, wc_cnt, last_cnt;
  logic        prev_stall;
  logic [63:0] prev_data;

`ifdef WRITE_LAST_CHECK_EN
  localparam logic ExpLastErr = 1'b1;
`else
  localparam logic ExpLastErr = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input logic [63:0] b);
    Start = 1'b1;
    Beat_Num_REG = BW'(n);
    tick();
    Start = 1'b0;
    n_beats = n; base = b;
    in_idx = 0; out_idx = 0; wc_cnt = 0; last_cnt = 0;
    prev_stall = 1'b0; prev_data = '0;
    S_Valid = (n > 0);
    S_Data  = b;
    S_Last  = (n == 1);
  endtask

  // mode: 0 = M_Ready high, 1 = random M_Ready, 2 = M_Ready low
  task automatic step(input int mode);
    logic ihs, ohs;
    ihs = S_Valid && S_Ready;
    ohs = M_Valid && M_Ready;
    if (prev_stall) chk("stall_hold", M_Data, prev_data);
    if (ohs) begin
      chk("out_data", M_Data, base + 64'(out_idx));
      chk("out_last", 64'(M_Last), 64'(out_idx == n_beats - 1));
      if (M_Last) last_cnt++;
      out_idx++;
    end
    if (Write_Complete) wc_cnt++;
    prev_stall = M_Valid && !M_Ready;
    prev_data  = M_Data;
    tick();
    if (ihs) in_idx++;
    S_Valid = (in_idx < n_beats);
    S_Data  = base + 64'(in_idx);
    S_Last  = (in_idx == n_beats - 1);
    M_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic finish_stream(input string tag, input int budget, input int mode);
    for (int c = 0; c < budget && wc_cnt == 0; c++) step(mode);
    step(mode);
    step(mode);
    chk({tag, "_beats_out"}, 64'(out_idx), 64'(n_beats));
    chk({tag, "_wc_pulses"}, 64'(wc_cnt), 64'd1);
    chk({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; Start = 1'b0; Beat_Num_REG = '0; S_Data = '0; S_Valid = 1'b0;
    S_Last = 1'b0; M_Ready = 1'b0;
    tick(); tick();
    chk("rst_s_ready", 64'(S_Ready), 64'd0);
    chk("rst_m_valid", 64'(M_Valid), 64'd0);
    chk("rst_m_last", 64'(M_Last), 64'd0);
    chk("rst_wc", 64'(Write_Complete), 64'd0);
    chk("rst_last_err", 64'(Last_Error), 64'd0);
    chk("rst_count", 64'(Fifo_Count), 64'd0);
    rst = 1'b1;
    tick();

    // 4 beats back-to-back, DMA always ready: data visible one cycle after push
    M_Ready = 1'b1;
    Start = 1'b1; Beat_Num_REG = 24'd4;
    tick();
    Start = 1'b0;
    S_Valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      S_Data = 64'(i);
      S_Last = (i == 4);
      if (i == 1) chk("t1_s_ready", 64'(S_Ready), 64'd1);
      tick();
      chk("t1_m_valid", 64'(M_Valid), 64'd1);
      chk("t1_m_data", M_Data, 64'(i));
      chk("t1_m_last", 64'(M_Last), 64'(i == 4));
      chk("t1_wc_early", 64'(Write_Complete), 64'd0);
    end
    S_Valid = 1'b0; S_Last = 1'b0;
    chk("t1_s_ready_done", 64'(S_Ready), 64'd0);
    tick();
    chk("t1_wc", 64'(Write_Complete), 64'd1);
    chk("t1_m_valid_empty", 64'(M_Valid), 64'd0);
    tick();
    chk("t1_wc_off", 64'(Write_Complete), 64'd0);
    chk("t1_last_err", 64'(Last_Error), 64'd0);

    // 6 beats into a 4-entry FIFO with DMA stalled, then released
    M_Ready = 1'b0;
    start_run(6, 64'h10);
    repeat (4) step(2);
    chk("t2_count_full", 64'(Fifo_Count), 64'd4);
    chk("t2_s_ready_full", 64'(S_Ready), 64'd0);
    chk("t2_head", M_Data, 64'h10);
    repeat (3) step(2);
    chk("t2_count_hold", 64'(Fifo_Count), 64'd4);
    chk("t2_in_stalled", 64'(in_idx), 64'd4);
    M_Ready = 1'b1;
    finish_stream("t2", 100, 0);

    // 100 beats with random DMA back-pressure
    start_run(100, 64'h1000);
    finish_stream("t3", 2000, 1);
    chk("t3_count_empty", 64'(Fifo_Count), 64'd0);

    // zero-beat layer completes without accepting data
    S_Valid = 1'b1; M_Ready = 1'b1;
    Start = 1'b1; Beat_Num_REG = '0;
    tick();
    Start = 1'b0;
    chk("t4_s_ready", 64'(S_Ready), 64'd0);
    chk("t4_wc", 64'(Write_Complete), 64'd1);
    tick();
    chk("t4_wc_off", 64'(Write_Complete), 64'd0);
    chk("t4_s_ready_idle", 64'(S_Ready), 64'd0);
    S_Valid = 1'b0;

    // asynchronous reset with three beats in flight
    M_Ready = 1'b0;
    start_run(8, 64'h200);
    repeat (3) step(2);
    chk("t5_count_pre", 64'(Fifo_Count), 64'd3);
    chk("t5_valid_pre", 64'(M_Valid), 64'd1);
    rst = 1'b0;
    #2;
    chk("t5_count", 64'(Fifo_Count), 64'd0);
    chk("t5_m_valid", 64'(M_Valid), 64'd0);
    chk("t5_m_last", 64'(M_Last), 64'd0);
    chk("t5_s_ready", 64'(S_Ready), 64'd0);
    chk("t5_wc", 64'(Write_Complete), 64'd0);
    #1;
    rst = 1'b1;
    S_Valid = 1'b0;
    tick();
    M_Ready = 1'b1;
    start_run(3, 64'h300);
    finish_stream("t5_rerun", 50, 0);
    chk("t5_last_err", 64'(Last_Error), 64'd0);

    // S_Last on beat 3 of 4 is a mismatch when checking is built in
    M_Ready = 1'b1;
    Start = 1'b1; Beat_Num_REG = 24'd4;
    tick();
    Start = 1'b0;
    S_Valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      S_Data = 64'(i);
      S_Last = (i == 3);
      tick();
    end
    S_Valid = 1'b0; S_Last = 1'b0;
    chk("t6_last_err", 64'(Last_Error), 64'(ExpLastErr));
    repeat (4) tick();
    chk("t6_last_err_sticky", 64'(Last_Error), 64'(ExpLastErr));
    start_run(1, 64'h400);
    chk("t6_last_err_clear", 64'(Last_Error), 64'd0);
    finish_stream("t6_rerun", 50, 0);
    chk("t6_last_err_final", 64'(Last_Error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
